// File: rtl/nfs_share_pkg.sv
// Shared constants and types for the nfs_open_file share-counter find/commit stages.
// Holds the mode encodings, default record offsets, error codes and the commit FSM states.
package nfs_share_pkg;

  localparam logic [31:0] ACCESS_READ  = 32'd1;
  localparam logic [31:0] ACCESS_WRITE = 32'd2;
  localparam logic [31:0] ACCESS_BOTH  = 32'd3;

  localparam logic [31:0] DENY_NONE  = 32'd0;
  localparam logic [31:0] DENY_READ  = 32'd1;
  localparam logic [31:0] DENY_WRITE = 32'd2;
  localparam logic [31:0] DENY_BOTH  = 32'd3;

  localparam logic [63:0] ACC_OFF_DEFAULT  = 64'h20;
  localparam logic [63:0] DENY_OFF_DEFAULT = 64'h28;
  localparam logic [63:0] CNT_BASE_DEFAULT = 64'h30;
  localparam int unsigned NUM_CNT          = 18;

  localparam logic [7:0] BUS_BE = 8'h0F;

  typedef enum logic [1:0] {
    ErrOk        = 2'd0,
    ErrBadMode   = 2'd1,
    ErrUnderflow = 2'd2
  } err_t;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StRdReq,
    StRdWait,
    StWrCnt,
    StWrAcc,
    StWrDeny,
    StDone
  } state_t;

endpackage

// File: rtl/nfs_share_cnt_index.sv
// Maps an (access, deny, delegated) triple onto one of the 18 share counters.
// Shared with the remove-open find stage.
module nfs_share_cnt_index
  import nfs_share_pkg::*;
(
  input  logic [31:0] access_i,
  input  logic [31:0] deny_i,
  input  logic [31:0] delegated_i,
  output logic        valid_o,
  output logic [4:0]  idx_o
);

  logic       a_ok;
  logic       d_ok;
  logic [1:0] a_idx;
  logic [1:0] d_idx;

  always_comb begin
    a_ok  = 1'b1;
    a_idx = 2'd0;
    case (access_i)
      ACCESS_READ:  a_idx = 2'd0;
      ACCESS_WRITE: a_idx = 2'd1;
      ACCESS_BOTH:  a_idx = 2'd2;
      default:      a_ok  = 1'b0;
    endcase
  end

  // Deny READ has no counter of its own and is rejected.
  always_comb begin
    d_ok  = 1'b1;
    d_idx = 2'd0;
    case (deny_i)
      DENY_NONE:  d_idx = 2'd0;
      DENY_WRITE: d_idx = 2'd1;
      DENY_BOTH:  d_idx = 2'd2;
      default:    d_ok  = 1'b0;
    endcase
  end

  always_comb begin
    valid_o = a_ok & d_ok;
    idx_o   = ((delegated_i != 32'd0) ? 5'd9 : 5'd0) + ({3'b000, d_idx} * 5'd3)
              + {3'b000, a_idx};
  end

endmodule

// File: rtl/nfs_open_file_remove_open_commit.sv
// Commit stage for removing an open: decrements the matching share counter in the
// nfs_open_file record and rewrites nof_access / nof_deny over a single avmm port.
module nfs_open_file_remove_open_commit
  import nfs_share_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [63:0] ACC_OFF      = ACC_OFF_DEFAULT,
  parameter logic [63:0] DENY_OFF     = DENY_OFF_DEFAULT,
  parameter logic [63:0] CNT_BASE     = CNT_BASE_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        stall,
  input  logic [63:0] nofp,
  input  logic [31:0] accessMode,
  input  logic [31:0] denyMode,
  input  logic [31:0] newAccessMode,
  input  logic [31:0] newDenyMode,
  input  logic [31:0] delegated,
  output logic [1:0]  error,
  output logic [63:0] avmm_0_rw_address,
  output logic [7:0]  avmm_0_rw_byteenable,
  output logic        avmm_0_rw_read,
  input  logic [63:0] avmm_0_rw_readdata,
  output logic        avmm_0_rw_write,
  output logic [63:0] avmm_0_rw_writedata
);

  localparam int unsigned LatW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'(READ_LATENCY - 1);

  state_t          state_q;
  err_t            err_q;
  logic [LatW-1:0] lat_q;
  logic [63:0]     nofp_q;
  logic [31:0]     acc_q;
  logic [31:0]     deny_q;
  logic [31:0]     new_acc_q;
  logic [31:0]     new_deny_q;
  logic            deleg_q;

  logic        idx_valid;
  logic [4:0]  idx;
  logic [63:0] cnt_addr;
  logic        unused_rdata_hi;

  nfs_share_cnt_index u_cnt_index (
    .access_i    (acc_q),
    .deny_i      (deny_q),
    .delegated_i ({31'b0, deleg_q}),
    .valid_o     (idx_valid),
    .idx_o       (idx)
  );

  assign cnt_addr        = nofp_q + CNT_BASE + {56'b0, idx, 3'b000};
  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StDone);
  assign error           = err_q;
  assign unused_rdata_hi = ^avmm_0_rw_readdata[63:32];

  // Bus outputs are registered on the transition into the state that owns them.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q              <= StIdle;
      err_q                <= ErrOk;
      lat_q                <= '0;
      nofp_q               <= '0;
      acc_q                <= '0;
      deny_q               <= '0;
      new_acc_q            <= '0;
      new_deny_q           <= '0;
      deleg_q              <= 1'b0;
      avmm_0_rw_address    <= '0;
      avmm_0_rw_byteenable <= '0;
      avmm_0_rw_read       <= 1'b0;
      avmm_0_rw_write      <= 1'b0;
      avmm_0_rw_writedata  <= '0;
    end else begin
      avmm_0_rw_read       <= 1'b0;
      avmm_0_rw_write      <= 1'b0;
      avmm_0_rw_byteenable <= 8'h00;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            nofp_q     <= nofp;
            acc_q      <= accessMode;
            deny_q     <= denyMode;
            new_acc_q  <= newAccessMode;
            new_deny_q <= newDenyMode;
            deleg_q    <= (delegated != 32'd0);
            err_q      <= ErrOk;
            state_q    <= StDecode;
          end
        end
        StDecode: begin
          // A bad mode spends a second cycle here so its return lands two cycles after accept.
          if (idx_valid) begin
            avmm_0_rw_read       <= 1'b1;
            avmm_0_rw_byteenable <= BUS_BE;
            avmm_0_rw_address    <= cnt_addr;
            state_q              <= StRdReq;
          end else if (err_q == ErrBadMode) begin
            state_q <= StDone;
          end else begin
            err_q <= ErrBadMode;
          end
        end
        StRdReq: begin
          lat_q   <= '0;
          state_q <= StRdWait;
        end
        StRdWait: begin
          if (lat_q == LatLast) begin
            state_q <= StWrCnt;
            if (avmm_0_rw_readdata[31:0] == 32'd0) begin
              err_q <= ErrUnderflow;
            end else begin
              avmm_0_rw_write      <= 1'b1;
              avmm_0_rw_byteenable <= BUS_BE;
              avmm_0_rw_address    <= cnt_addr;
              avmm_0_rw_writedata  <= {32'h0, avmm_0_rw_readdata[31:0] - 32'd1};
            end
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        StWrCnt: begin
          // On underflow this cycle carries no strobe and the record is left untouched.
          if (err_q == ErrUnderflow) begin
            state_q <= StDone;
          end else begin
            avmm_0_rw_write      <= 1'b1;
            avmm_0_rw_byteenable <= BUS_BE;
            avmm_0_rw_address    <= nofp_q + ACC_OFF;
            avmm_0_rw_writedata  <= {32'h0, new_acc_q};
            state_q              <= StWrAcc;
          end
        end
        StWrAcc: begin
          avmm_0_rw_write      <= 1'b1;
          avmm_0_rw_byteenable <= BUS_BE;
          avmm_0_rw_address    <= nofp_q + DENY_OFF;
          avmm_0_rw_writedata  <= {32'h0, new_deny_q};
          state_q              <= StWrDeny;
        end
        StWrDeny: begin
          state_q <= StDone;
        end
        StDone: begin
          if (!stall) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nfs_open_file_remove_open_commit.sv
// Randomised scoreboard bench for the remove-open commit stage: a driver pushes the bus
// transactions and return predicted by a reference model, a monitor pops them as they appear.
module tb_nfs_open_file_remove_open_commit;

  parameter int unsigned RL = 1;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic        busy;
  logic        done;
  logic        stall;
  logic [63:0] nofp;
  logic [31:0] accessMode;
  logic [31:0] denyMode;
  logic [31:0] newAccessMode;
  logic [31:0] newDenyMode;
  logic [31:0] delegated;
  logic [1:0]  error;
  logic [63:0] avmm_0_rw_address;
  logic [7:0]  avmm_0_rw_byteenable;
  logic        avmm_0_rw_read;
  logic [63:0] avmm_0_rw_readdata;
  logic        avmm_0_rw_write;
  logic [63:0] avmm_0_rw_writedata;

  always #5 clock = ~clock;

  nfs_open_file_remove_open_commit #(
    .READ_LATENCY (RL)
  ) dut (
    .clock                (clock),
    .resetn               (resetn),
    .start                (start),
    .busy                 (busy),
    .done                 (done),
    .stall                (stall),
    .nofp                 (nofp),
    .accessMode           (accessMode),
    .denyMode             (denyMode),
    .newAccessMode        (newAccessMode),
    .newDenyMode          (newDenyMode),
    .delegated            (delegated),
    .error                (error),
    .avmm_0_rw_address    (avmm_0_rw_address),
    .avmm_0_rw_byteenable (avmm_0_rw_byteenable),
    .avmm_0_rw_read       (avmm_0_rw_read),
    .avmm_0_rw_readdata   (avmm_0_rw_readdata),
    .avmm_0_rw_write      (avmm_0_rw_write),
    .avmm_0_rw_writedata  (avmm_0_rw_writedata)
  );

  // kind: 0 read, 1 write, 2 done (addr = latency in cycles, data = error code)
  typedef struct {
    int          kind;
    logic [63:0] addr;
    logic [63:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  logic [31:0] rd_val = 32'd0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Reference model: what the share rules say must appear on the bus for one command.
  task automatic push_model(input logic [63:0] base, input logic [31:0] acc, input logic [31:0] dny,
                            input logic [31:0] dlg, input logic [31:0] na, input logic [31:0] nd,
                            input logic [31:0] rdv, output int err);
    int          aidx;
    int          didx;
    int          idx;
    logic [63:0] caddr;
    if (!(acc inside {32'd1, 32'd2, 32'd3}) || !(dny inside {32'd0, 32'd2, 32'd3})) begin
      err = 1;
      exp_q.push_back('{kind: 2, addr: 64'd2, data: 64'd1});
      return;
    end
    aidx  = int'(acc) - 1;
    didx  = (dny == 32'd0) ? 0 : int'(dny) - 1;
    idx   = ((dlg != 32'd0) ? 9 : 0) + 3 * didx + aidx;
    caddr = base + 64'h30 + 64'(8 * idx);
    exp_q.push_back('{kind: 0, addr: caddr, data: 64'd0});
    if (rdv == 32'd0) begin
      err = 2;
      exp_q.push_back('{kind: 2, addr: 64'(3 + RL), data: 64'd2});
    end else begin
      err = 0;
      exp_q.push_back('{kind: 1, addr: caddr, data: {32'h0, rdv - 32'd1}});
      exp_q.push_back('{kind: 1, addr: base + 64'h20, data: {32'h0, na}});
      exp_q.push_back('{kind: 1, addr: base + 64'h28, data: {32'h0, nd}});
      exp_q.push_back('{kind: 2, addr: 64'(5 + RL), data: 64'd0});
    end
  endtask

  // Memory: answers a read with the counter value exactly RL cycles after the strobe.
  initial begin
    avmm_0_rw_readdata = 64'hDEAD_BEEF_DEAD_BEEF;
    forever begin
      @(negedge clock);
      if (resetn && avmm_0_rw_read) begin
        repeat (RL) @(posedge clock);
        #1 avmm_0_rw_readdata = {$urandom, rd_val};
        @(posedge clock);
        #1 avmm_0_rw_readdata = {$urandom, $urandom};
      end
    end
  end

  // Monitor
  initial begin
    ev_t  e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        prev_done = 1'b0;
      end else begin
        if (avmm_0_rw_read || avmm_0_rw_write) begin
          chk("one_strobe", {63'b0, avmm_0_rw_read & avmm_0_rw_write}, 64'd0);
          chk("byteenable", {56'b0, avmm_0_rw_byteenable}, 64'h0F);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_strobe: got addr 0x%0h, expected no traffic",
                     avmm_0_rw_address);
          end else begin
            e = exp_q.pop_front();
            chk("strobe_kind", avmm_0_rw_write ? 64'd1 : 64'd0, 64'(e.kind));
            chk("strobe_addr", avmm_0_rw_address, e.addr);
            if (avmm_0_rw_write) chk("writedata", avmm_0_rw_writedata, e.data);
          end
        end
        if (done && !prev_done) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_done: got done=1, expected no return");
          end else begin
            e = exp_q.pop_front();
            chk("done_kind", 64'd2, 64'(e.kind));
            chk("done_latency", 64'(cyc - accept_cyc), e.addr);
            chk("done_error", {62'b0, error}, e.data);
          end
        end
        prev_done = done;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
    chk({tag, "_done"}, {63'b0, done}, 64'd0);
    chk({tag, "_read"}, {63'b0, avmm_0_rw_read}, 64'd0);
    chk({tag, "_write"}, {63'b0, avmm_0_rw_write}, 64'd0);
    chk({tag, "_error"}, {62'b0, error}, 64'd0);
    chk({tag, "_addr"}, avmm_0_rw_address, 64'd0);
    chk({tag, "_be"}, {56'b0, avmm_0_rw_byteenable}, 64'd0);
    chk({tag, "_wdata"}, avmm_0_rw_writedata, 64'd0);
  endtask

  task automatic issue(input logic [63:0] base, input logic [31:0] acc, input logic [31:0] dny,
                       input logic [31:0] dlg, input logic [31:0] na, input logic [31:0] nd,
                       input logic [31:0] rdv, input int stall_n, input bit rst_mid);
    int exp_err;
    int n_done;
    int guard;
    guard = 0;
    @(negedge clock);
    while (busy && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (busy) begin
      n_vec++;
      n_miss++;
      $display("FAIL idle_timeout: got busy=1, expected idle within 100 cycles");
    end
    rd_val = rdv;
    push_model(base, acc, dny, dlg, na, nd, rdv, exp_err);
    nofp          = base;
    accessMode    = acc;
    denyMode      = dny;
    delegated     = dlg;
    newAccessMode = na;
    newDenyMode   = nd;
    stall         = (stall_n > 0);
    start         = 1'b1;
    @(posedge clock);
    #1;
    start      = 1'b0;
    accept_cyc = cyc;
    chk("accept_busy", {63'b0, busy}, 64'd1);
    // Scramble inputs so any failure to latch at accept shows up.
    nofp          = {$urandom, $urandom};
    accessMode    = $urandom;
    denyMode      = $urandom;
    delegated     = $urandom;
    newAccessMode = $urandom;
    newDenyMode   = $urandom;

    if (rst_mid) begin
      repeat (3 + RL) @(posedge clock);
      @(negedge clock);
      #2 resetn = 1'b0;
      // The deny write and the return must never happen.
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      #1 check_reset_outputs("midrst");
      @(negedge clock);
      resetn = 1'b1;
      return;
    end

    guard = 0;
    while (!done && guard < 60) begin
      @(negedge clock);
      guard++;
    end
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("FAIL done_timeout: got done=0, expected done within 60 cycles");
      stall = 1'b0;
      return;
    end
    n_done = 0;
    while (done && n_done < 20) begin
      n_done++;
      chk("busy_at_done", {63'b0, busy}, 64'd1);
      stall = (n_done <= stall_n);
      start = (n_done == 2) || (n_done == stall_n + 1);
      accessMode = 32'd3;
      denyMode   = 32'd0;
      @(negedge clock);
      start = 1'b0;
    end
    stall = 1'b0;
    chk("done_cycles", 64'(n_done), 64'(stall_n + 1));
    chk("idle_after_done", {63'b0, busy}, 64'd0);
    chk("error_hold", {62'b0, error}, 64'(exp_err));
    @(negedge clock);
    chk("start_ignored", {63'b0, busy}, 64'd0);
    chk("error_hold2", {62'b0, error}, 64'(exp_err));
  endtask

  initial begin
    logic [63:0] b;
    resetn        = 1'b0;
    start         = 1'b0;
    stall         = 1'b0;
    nofp          = '0;
    accessMode    = '0;
    denyMode      = '0;
    newAccessMode = '0;
    newDenyMode   = '0;
    delegated     = '0;
    repeat (3) @(posedge clock);
    #1 check_reset_outputs("reset");
    @(negedge clock);
    resetn = 1'b1;

    issue(64'h1000, 32'd3, 32'd0, 32'd0, 32'd1, 32'd0, 32'd5, 0, 1'b0);
    issue(64'h1000, 32'd1, 32'd3, 32'd1, 32'd2, 32'd2, 32'd1, 0, 1'b0);
    issue(64'h1000, 32'd3, 32'd1, 32'd0, 32'd1, 32'd1, 32'd7, 0, 1'b0);
    issue(64'h1000, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd7, 0, 1'b0);
    issue(64'h1000, 32'd2, 32'd5, 32'd0, 32'd1, 32'd1, 32'd7, 0, 1'b0);
    issue(64'h2000, 32'd2, 32'd2, 32'd0, 32'd1, 32'd1, 32'd0, 0, 1'b0);
    issue(64'h3000, 32'd3, 32'd2, 32'd4, 32'd3, 32'd2, 32'd9, 3, 1'b0);
    issue(64'h4000, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd2, 1, 1'b0);
    issue(64'h5000, 32'd2, 32'd0, 32'd1, 32'd2, 32'd0, 32'd3, 0, 1'b1);
    issue(64'h1000, 32'd3, 32'd0, 32'd0, 32'd1, 32'd0, 32'd5, 0, 1'b0);
    issue(64'hFFFF_FFFF_FFFF_FFF0, 32'd3, 32'd3, 32'd1, 32'd3, 32'd3, 32'h8000_0000, 0, 1'b0);
    issue(64'hFFFF_FFFF_FFFF_FFF0, 32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1, 2, 1'b0);

    for (int i = 0; i < 40; i++) begin
      b = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 31) * 8)
                                       : {$urandom, $urandom} & ~64'h7;
      issue(b, 32'($urandom_range(0, 4)), 32'($urandom_range(0, 4)),
            ($urandom_range(0, 1) == 1) ? $urandom : 32'd0, $urandom_range(0, 3),
            $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
            int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (4) @(negedge clock);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
